psram_qspi_master: RTL and testbench

- QSPI initiator that drives the on-board PSRAM responder (sck, ce_n, 4-bit dio) from a simple single-outstanding request/response bus on the SoC side.
- Issues write command 0x38 and quad read 0xEB, each with a 24-bit address. Transfers 1–4 bytes per transaction.
- Sits between the SoC bus bridge and the top-level PSRAM pads; the tristate buffer itself lives at the pad level.

---
 rtl/psram_qspi_master.sv | 175 +++++++++++++++++
 tb/tb_psram_qspi_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qspi_master.sv
// QSPI initiator for the on-board PSRAM: turns single-outstanding bus requests into
// quad write (0x38) / quad read (0xEB) transfers of 1-4 bytes with a 24-bit address.
module psram_qspi_master #(
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned DUMMY_CYCLES   = 6,
    parameter int unsigned CE_HIGH_CYCLES = 2,
    parameter logic [7:0]  CMD_READ       = 8'hEB,
    parameter logic [7:0]  CMD_WRITE      = 8'h38
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_out,
    output logic        dio_oe,
    input  logic [3:0]  dio_in
);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CE_CLKS = CE_HIGH_CYCLES * 2 * CLK_DIV;
    localparam int unsigned CE_W    = (CE_CLKS > 1) ? $clog2(CE_CLKS) : 1;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_CE_HIGH, S_RESP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CE_W-1:0]  ce_cnt;
    logic             write_q;
    logic [23:0]      addr_q;
    logic [2:0]       len_q;
    logic [31:0]      wdata_q;

    logic [CNT_W-1:0] phase_len;
    state_t           phase_next;
    logic [2:0]       len_eff;

    // Length of the current serial phase in sck cycles and the phase that follows it
    always_comb begin
        phase_len  = CNT_W'(8);
        phase_next = S_ADDR;
        case (state)
            S_CMD: begin
                phase_len  = CNT_W'(8);
                phase_next = S_ADDR;
            end
            S_ADDR: begin
                phase_len  = CNT_W'(6);
                phase_next = write_q ? S_WDATA : ((DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY);
            end
            S_WDATA: begin
                phase_len  = CNT_W'({len_q, 1'b0});
                phase_next = S_CE_HIGH;
            end
            S_DUMMY: begin
                phase_len  = CNT_W'(DUMMY_CYCLES);
                phase_next = S_RDATA;
            end
            S_RDATA: begin
                phase_len  = CNT_W'({len_q, 1'b0});
                phase_next = S_CE_HIGH;
            end
            default: ;
        endcase
    end

    assign len_eff = (req_len == 3'd0 || req_len > 3'd4) ? 3'd4 : req_len;

    // Nibble presented on dio_out for sck cycle idx of a driven phase
    function automatic logic [3:0] nibble(input state_t st, input logic [2:0] idx);
        logic [7:0] op;
        op = write_q ? CMD_WRITE : CMD_READ;
        case (st)
            S_CMD:   nibble = {3'b000, op[3'd7 - idx]};
            S_ADDR:  nibble = 4'(addr_q >> (5'd20 - {idx, 2'b00}));
            S_WDATA: nibble = 4'(wdata_q >> {idx[2:1], ~idx[0], 2'b00});
            default: nibble = 4'h0;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            sck        <= 1'b0;
            ce_n       <= 1'b1;
            dio_out    <= 4'h0;
            dio_oe     <= 1'b0;
            div_cnt    <= '0;
            cyc_cnt    <= '0;
            ce_cnt     <= '0;
            write_q    <= 1'b0;
            addr_q     <= 24'h0;
            len_q      <= 3'd4;
            wdata_q    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q    <= req_write;
                        addr_q     <= req_addr;
                        len_q      <= len_eff;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'h0;
                        ce_n       <= 1'b0;
                        sck        <= 1'b0;
                        dio_oe     <= 1'b1;
                        dio_out    <= {3'b000, req_write ? CMD_WRITE[7] : CMD_READ[7]};
                        div_cnt    <= '0;
                        cyc_cnt    <= '0;
                        state      <= S_CMD;
                    end
                end
                S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            // rising edge: capture read nibble, high nibble of each byte first
                            if (state == S_RDATA)
                                resp_rdata[{cyc_cnt[2:1], ~cyc_cnt[0], 2'b00} +: 4] <= dio_in;
                        end else if (cyc_cnt == phase_len - CNT_W'(1)) begin
                            cyc_cnt <= '0;
                            state   <= phase_next;
                            if (phase_next == S_CE_HIGH) begin
                                ce_n    <= 1'b1;
                                dio_oe  <= 1'b0;
                                dio_out <= 4'h0;
                                ce_cnt  <= '0;
                            end else begin
                                dio_oe  <= (phase_next == S_ADDR) || (phase_next == S_WDATA);
                                dio_out <= nibble(phase_next, 3'd0);
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                            dio_out <= nibble(state, 3'(cyc_cnt + CNT_W'(1)));
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_CE_HIGH: begin
                    if (ce_cnt == CE_W'(CE_CLKS - 1)) begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        ce_cnt <= ce_cnt + CE_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_qspi_master.sv
// Bench for psram_qspi_master: behavioural PSRAM device plus byte-level reference memory,
// directed table, randomized transactions, backpressure, mid-read reset and CLK_DIV=3 timing.
module tb_psram_qspi_master;
    localparam logic [7:0] OP_W = 8'h38;
    localparam logic [7:0] OP_R = 8'hEB;
    localparam int DUMMY = 6;

    logic        clock = 1'b0;
    logic        reset, reset3;
    logic        req_valid, req_write, resp_ready;
    logic [23:0] req_addr;
    logic [2:0]  req_len;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, sck, ce_n, dio_oe;
    logic [31:0] resp_rdata;
    logic [3:0]  dio_out;
    logic [3:0]  dio_in = 4'h0;

    logic        req_valid3, req_write3, resp_ready3;
    logic [23:0] req_addr3;
    logic [2:0]  req_len3;
    logic [31:0] req_wdata3;
    logic        req_ready3, resp_valid3, sck3, ce_n3, dio_oe3;
    logic [31:0] resp_rdata3;
    logic [3:0]  dio_out3;
    logic [3:0]  dio_in3 = 4'hA;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    psram_qspi_master u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sck(sck), .ce_n(ce_n), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
    );

    psram_qspi_master #(.CLK_DIV(3)) u_div3 (
        .clock(clock), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write3), .req_addr(req_addr3), .req_len(req_len3), .req_wdata(req_wdata3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
        .sck(sck3), .ce_n(ce_n3), .dio_out(dio_out3), .dio_oe(dio_oe3), .dio_in(dio_in3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference memory ----------------
    logic [7:0] ref_mem [int];
    logic [7:0] dev_mem [int];

    function automatic int eff_len(input logic [2:0] l);
        return (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        int k = a & 32'h00FF_FFFF;
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_read(input logic [23:0] a, input logic [2:0] l);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < eff_len(l); i++) r[8*i +: 8] = ref_byte(int'(a) + i);
        return r;
    endfunction

    task automatic ref_write(input logic [23:0] a, input logic [2:0] l, input logic [31:0] wd);
        for (int i = 0; i < eff_len(l); i++) ref_mem[(int'(a) + i) & 32'h00FF_FFFF] = wd[8*i +: 8];
    endtask

    // ---------------- behavioural PSRAM device ----------------
    int          dev_edges = 0;
    int          dev_k;
    logic [7:0]  dev_cmd = 8'h0;
    logic [23:0] dev_addr = 24'h0;
    logic [3:0]  dev_hi = 4'h0;
    logic [7:0]  dev_b;

    always @(negedge ce_n) begin
        dev_edges = 0;
        dev_cmd   = 8'h0;
        dev_addr  = 24'h0;
    end

    always @(posedge sck) begin
        if (!ce_n) begin
            dev_edges++;
            if (dev_edges <= 14 || dev_cmd == OP_W) check("oe_driven", 32'(dio_oe), 32'd1);
            else check("oe_released", 32'(dio_oe), 32'd0);
            if (dev_edges <= 8) begin
                dev_cmd = {dev_cmd[6:0], dio_out[0]};
                check("cmd_upper_zero", 32'(dio_out[3:1]), 32'd0);
            end else if (dev_edges <= 14) begin
                dev_addr = {dev_addr[19:0], dio_out};
            end else if (dev_cmd == OP_W) begin
                dev_k = dev_edges - 15;
                if (dev_k % 2 == 0) dev_hi = dio_out;
                else dev_mem[(int'(dev_addr) + dev_k / 2) & 32'h00FF_FFFF] = {dev_hi, dio_out};
            end
        end
    end

    always @(negedge sck) begin
        if (!ce_n && dev_cmd == OP_R && dev_edges >= 14 + DUMMY) begin
            dev_k = dev_edges - (14 + DUMMY);
            dev_b = dev_mem.exists((int'(dev_addr) + dev_k / 2) & 32'h00FF_FFFF) ?
                    dev_mem[(int'(dev_addr) + dev_k / 2) & 32'h00FF_FFFF] : 8'h00;
            dio_in = (dev_k % 2 == 0) ? dev_b[7:4] : dev_b[3:0];
        end
    end

    // sck must be idle low whenever ce_n is high
    always @(negedge clock) if (!reset && ce_n) check("sck_idle_low", 32'(sck), 32'd0);

    // ---------------- CLK_DIV=3 timing monitor ----------------
    logic p_sck3 = 1'b0, p_ce3 = 1'b1;
    logic [3:0] p_dio3 = 4'h0;
    int  since_rise3 = -1, ce_high3 = 0, rises3 = 0, last_rises3 = 0;
    bit  seen_ce_rise3 = 1'b0;

    always @(negedge clock) begin
        if (!reset3) begin
            if (dio_out3 !== p_dio3)
                check("div3_dio_on_fall", 32'((p_sck3 && !sck3) || (p_ce3 && !ce_n3)), 32'd1);
            if (since_rise3 >= 0) since_rise3++;
            if (!p_sck3 && sck3) begin
                rises3++;
                if (since_rise3 >= 0) check("div3_sck_period", 32'(since_rise3), 32'd6);
                since_rise3 = 0;
            end
            if (p_ce3 && !ce_n3) begin
                if (seen_ce_rise3) check("div3_ce_high_min", 32'(ce_high3 >= 12), 32'd1);
                rises3 = 0;
                since_rise3 = -1;
            end
            if (!p_ce3 && ce_n3) begin
                seen_ce_rise3 = 1'b1;
                ce_high3 = 0;
                last_rises3 = rises3;
            end
            if (ce_n3) ce_high3++;
        end
        p_sck3 = sck3;
        p_ce3  = ce_n3;
        p_dio3 = dio_out3;
    end

    // ---------------- transactors ----------------
    task automatic transact(input logic w, input logic [23:0] a, input logic [2:0] l,
                            input logic [31:0] wd, output logic [31:0] rd, output int rises);
        int t = 0;
        @(negedge clock);
        while (!req_ready && t < 1000) begin @(negedge clock); t++; end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 2000) begin @(negedge clock); t++; end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        rises = dev_edges;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic w, input logic [23:0] a,
                               input logic [2:0] l, input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] rd;
        int rises;
        transact(w, a, l, wd, rd, rises);
        check({tag, "_rdata"}, rd, exp);
        check({tag, "_sck_rises"}, 32'(rises), 32'(w ? 14 + 2 * eff_len(l) : 14 + DUMMY + 2 * eff_len(l)));
        check({tag, "_opcode"}, 32'(dev_cmd), 32'(w ? OP_W : OP_R));
        check({tag, "_addr"}, 32'(dev_addr), 32'(a));
        if (w) ref_write(a, l, wd);
    endtask

    task automatic transact3(input logic w, input logic [23:0] a, input logic [2:0] l,
                             input logic [31:0] wd, output logic [31:0] rd);
        int t = 0;
        @(negedge clock);
        while (!req_ready3 && t < 1000) begin @(negedge clock); t++; end
        if (!req_ready3) check("div3_req_ready_timeout", 32'd0, 32'd1);
        req_valid3 = 1'b1; req_write3 = w; req_addr3 = a; req_len3 = l; req_wdata3 = wd;
        @(negedge clock);
        req_valid3 = 1'b0;
        t = 0;
        while (!resp_valid3 && t < 4000) begin @(negedge clock); t++; end
        if (!resp_valid3) check("div3_resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata3;
        resp_ready3 = 1'b1;
        @(negedge clock);
        resp_ready3 = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [23:0] a;
        logic [2:0]  l;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        logic [31:0] rd, held;
        int          t;
        bit          started;

        tbl[0] = '{1'b1, 24'h000010, 3'd4, 32'hDDCCBBAA, 32'h00000000};
        tbl[1] = '{1'b0, 24'h000010, 3'd4, 32'h0,        32'hDDCCBBAA};
        tbl[2] = '{1'b0, 24'h000013, 3'd1, 32'h0,        32'h000000DD};
        tbl[3] = '{1'b0, 24'h000010, 3'd0, 32'h0,        32'hDDCCBBAA};
        tbl[4] = '{1'b1, 24'h000011, 3'd2, 32'h12345566, 32'h00000000};
        tbl[5] = '{1'b0, 24'h000010, 3'd7, 32'h0,        32'hDD5566AA};
        tbl[6] = '{1'b0, 24'h000012, 3'd3, 32'h0,        32'h0000DD55};

        reset = 1'b1; reset3 = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 24'h0; req_len = 3'd0; req_wdata = 32'h0;
        resp_ready = 1'b0;
        req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = 24'h0; req_len3 = 3'd0; req_wdata3 = 32'h0;
        resp_ready3 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_dio_out", 32'(dio_out), 32'd0);
        check("rst_dio_oe", 32'(dio_oe), 32'd0);
        @(negedge clock);
        reset = 1'b0; reset3 = 1'b0;

        for (int i = 0; i < 7; i++) run_checked($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].wd, tbl[i].exp);

        // randomized traffic in a small window so reads hit earlier writes
        for (int i = 0; i < 40; i++) begin
            logic w;
            logic [23:0] a;
            logic [2:0] l;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            a  = 24'h000100 + 24'($urandom_range(0, 31));
            l  = 3'($urandom_range(0, 7));
            wd = $urandom;
            run_checked($sformatf("rnd%0d", i), w, a, l, wd, w ? 32'h0 : ref_read(a, l));
        end

        // backpressure: response held, request pulse ignored
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000010; req_len = 3'd4;
        @(negedge clock);
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 2000) begin @(negedge clock); t++; end
        if (!resp_valid) check("bp_resp_timeout", 32'd0, 32'd1);
        held = resp_rdata;
        check("bp_rdata", held, ref_read(24'h000010, 3'd4));
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin req_valid = 1'b1; req_write = 1'b1; end
            if (i == 5) req_valid = 1'b0;
            @(negedge clock);
            check("bp_valid_held", 32'(resp_valid), 32'd1);
            check("bp_rdata_stable", resp_rdata, held);
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            check("bp_ce_n_high", 32'(ce_n), 32'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("bp_req_ready_back", 32'(req_ready), 32'd1);
        check("bp_resp_valid_drop", 32'(resp_valid), 32'd0);
        started = 1'b0;
        repeat (20) begin @(negedge clock); if (!ce_n) started = 1'b1; end
        check("bp_pulse_not_queued", 32'(started), 32'd0);

        // reset during RDATA aborts cleanly
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000010; req_len = 3'd4;
        @(negedge clock);
        req_valid = 1'b0;
        t = 0;
        while (dev_edges < 23 && t < 500) begin @(negedge clock); t++; end
        check("rd_reached_rdata", 32'(dev_edges >= 23), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_ce_n", 32'(ce_n), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_dio_oe", 32'(dio_oe), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        started = 1'b0;
        repeat (40) begin @(negedge clock); if (resp_valid) started = 1'b1; end
        check("abort_no_response", 32'(started), 32'd0);
        run_checked("after_abort", 1'b0, 24'h000010, 3'd4, 32'h0, ref_read(24'h000010, 3'd4));

        // CLK_DIV=3 instance: back-to-back transfers, device drives constant 0xA
        transact3(1'b1, 24'h000200, 3'd2, 32'h0000BEEF, rd);
        check("div3_w1_rdata", rd, 32'h0);
        check("div3_w1_rises", 32'(last_rises3), 32'd18);
        transact3(1'b1, 24'h000204, 3'd2, 32'h0000CAFE, rd);
        check("div3_w2_rdata", rd, 32'h0);
        check("div3_w2_rises", 32'(last_rises3), 32'd18);
        transact3(1'b0, 24'h000200, 3'd2, 32'h0, rd);
        check("div3_r_rdata", rd, 32'h0000AAAA);
        check("div3_r_rises", 32'(last_rises3), 32'd24);

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
